// File: rtl/asy_dual_port.sv
// Simple dual-port register-file RAM: one write port and one registered read port
// on a single clock, with synchronous whole-array clear and illegal-address flags.
module asy_dual_port #(
   parameter int WIDTH      = 16,
   parameter int DEPTH      = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  write,
   input  logic                  read,
   input  logic [WIDTH-1:0]      data_in,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [WIDTH-1:0]      data_out,
   output logic                  rd_valid,
   output logic                  wr_err,
   output logic                  rd_err
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // DEPTH <= 2**ADDR_WIDTH, so one extra bit always holds it exactly.
   localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic             wr_legal;
   logic             rd_legal;
   logic             wr_en;
   logic             rd_en;
   logic             fwd;
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] rd_idx;

   // Illegal addresses are flagged, never aliased onto a legal word.
   assign wr_legal = ({1'b0, wr_addr} < DEPTH_LIM);
   assign rd_legal = ({1'b0, rd_addr} < DEPTH_LIM);
   assign wr_en    = write & wr_legal;
   assign rd_en    = read & rd_legal;
   assign wr_idx   = wr_addr[IDX_W-1:0];
   assign rd_idx   = rd_addr[IDX_W-1:0];
   // Same-address read during a write returns the incoming data (write-first).
   assign fwd      = wr_en && (wr_addr == rd_addr);

   // Storage, registered read data and one-cycle status pulses; clr wins over both ports.
   always_ff @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         data_out <= '0;
         rd_valid <= 1'b0;
         wr_err   <= 1'b0;
         rd_err   <= 1'b0;
      end else begin
         if (wr_en) begin
            mem[wr_idx] <= data_in;
         end
         wr_err   <= write & ~wr_legal;
         rd_valid <= rd_en;
         rd_err   <= read & ~rd_legal;
         if (rd_en) begin
            data_out <= fwd ? data_in : mem[rd_idx];
         end else if (read) begin
            data_out <= '0;
         end
      end
   end

endmodule

// File: tb/tb_asy_dual_port.sv
// Scoreboard bench for asy_dual_port: stimulus pushes per-cycle expected outputs from
// an array-based model; an independent monitor pops and compares on the falling edge.
module tb_asy_dual_port;

   logic        clk = 1'b0;
   logic        clr = 1'b0;
   logic        write = 1'b0;
   logic        read = 1'b0;
   logic [15:0] data_in = 16'h0000;
   logic [3:0]  wr_addr = 4'h0;
   logic [3:0]  rd_addr = 4'h0;
   logic [15:0] data_out;
   logic        rd_valid;
   logic        wr_err;
   logic        rd_err;

   asy_dual_port #(.WIDTH(16), .DEPTH(8), .ADDR_WIDTH(4)) dut (
      .clk(clk), .clr(clr), .write(write), .read(read), .data_in(data_in),
      .wr_addr(wr_addr), .rd_addr(rd_addr), .data_out(data_out),
      .rd_valid(rd_valid), .wr_err(wr_err), .rd_err(rd_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      string       tag;
      logic [15:0] dout;
      logic        valid;
      logic        rerr;
      logic        werr;
   } exp_t;

   exp_t        sb[$];
   int          cyc_cnt = 0;
   int          n_checks = 0;
   int          n_pass = 0;
   logic [15:0] model_mem [8];
   logic [15:0] model_dout = 16'h0000;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // Monitor: compare every expectation due at this cycle.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
         exp_t e;
         e = sb.pop_front();
         n_checks++;
         if (e.cyc == cyc_cnt && data_out === e.dout && rd_valid === e.valid &&
             rd_err === e.rerr && wr_err === e.werr) begin
            n_pass++;
         end else begin
            $display("FAIL %s cyc=%0d: got dout=%h valid=%b rd_err=%b wr_err=%b, expected dout=%h valid=%b rd_err=%b wr_err=%b",
                     e.tag, e.cyc, data_out, rd_valid, rd_err, wr_err, e.dout, e.valid, e.rerr, e.werr);
         end
      end
   end

   // One clock of stimulus; the model states what the outputs must be after this edge.
   task automatic step(input string tag, input logic c, input logic w, input logic [3:0] wa,
                       input logic [15:0] wd, input logic r, input logic [3:0] ra);
      exp_t e;
      clr = c; write = w; wr_addr = wa; data_in = wd; read = r; rd_addr = ra;
      e.cyc = cyc_cnt + 1;
      e.tag = tag;
      e.valid = 1'b0; e.rerr = 1'b0; e.werr = 1'b0;
      if (c) begin
         foreach (model_mem[i]) model_mem[i] = 16'h0000;
         model_dout = 16'h0000;
      end else begin
         if (w && wa < 8) model_mem[wa[2:0]] = wd;
         if (w && wa >= 8) e.werr = 1'b1;
         if (r && ra < 8) begin
            model_dout = model_mem[ra[2:0]];
            e.valid = 1'b1;
         end else if (r) begin
            model_dout = 16'h0000;
            e.rerr = 1'b1;
         end
      end
      e.dout = model_dout;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input string tag);
      step(tag, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h0);
   endtask

   task automatic rd(input string tag, input logic [3:0] a);
      step(tag, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b1, a);
   endtask

   task automatic wr(input string tag, input logic [3:0] a, input logic [15:0] d);
      step(tag, 1'b0, 1'b1, a, d, 1'b0, 4'h0);
   endtask

   initial begin
      logic [3:0]  prev;
      logic [15:0] val;

      step("reset_clear", 1'b1, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h0);
      for (int a = 0; a < 8; a++) rd("read_after_clear", 4'(a));

      wr("write_a3", 4'd3, 16'h1234);
      wr("write_a7", 4'd7, 16'hBEEF);
      rd("readback_a3", 4'd3);
      rd("readback_a7", 4'd7);
      rd("untouched_a0", 4'd0);

      wr("write_a5", 4'd5, 16'h0001);
      step("collision_wr_first", 1'b0, 1'b1, 4'd5, 16'h00AA, 1'b1, 4'd5);
      rd("after_collision_a5", 4'd5);

      wr("illegal_write_a9", 4'd9, 16'hFFFF);
      for (int a = 0; a < 8; a++) rd("legal_after_bad_write", 4'(a));
      rd("illegal_read_a12", 4'd12);

      rd("read_beef", 4'd7);
      for (int k = 0; k < 3; k++) idle("hold_beef");

      step("clr_over_write", 1'b1, 1'b1, 4'd2, 16'h5555, 1'b0, 4'h0);
      rd("a2_after_clr", 4'd2);

      prev = 4'd0;
      for (int k = 0; k < 10; k++) begin
         val = 16'($urandom);
         step("independent_ports", 1'b0, 1'b1, 4'(k % 8), val, k > 0, prev);
         prev = 4'(k % 8);
      end

      for (int k = 0; k < 300; k++) begin
         step("random_mix", ($urandom_range(39) == 0), 1'($urandom), 4'($urandom_range(15)),
              16'($urandom), 1'($urandom), 4'($urandom_range(15)));
      end

      idle("drain");
      for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
      if (sb.size() > 0) begin
         n_checks++;
         $display("FAIL drain_timeout: %0d expectations pending, expected 0", sb.size());
      end
      #2;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
